// File: rtl/lc3_mem_sequencer_pkg.sv
// Shared types and encodings for the LC-3 memory transaction sequencer.
package lc3_mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WRITE = 3'd3,
    RWAIT = 3'd4,
    RLOAD = 3'd5,
    RCAPT = 3'd6,
    DONE  = 3'd7
  } state_e;

  // MDR source select as seen by the datapath mux
  localparam logic [1:0] SEL_MDR_NONE = 2'b00;
  localparam logic [1:0] SEL_MDR_MEM  = 2'b01;
  localparam logic [1:0] SEL_MDR_SPC  = 2'b11;

  // Requester identity held while a transaction is in flight
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

endpackage

// File: rtl/lc3_mem_sequencer_if.sv
// Requester handshakes plus the MAR/MDR/memory special-input controls.
// master = the sequencer, slave = requesters and datapath.
interface lc3_mem_sequencer_if #(
  parameter int AW = 16,
  parameter int DW = 16
) ();

  // requester side
  logic          run_en;
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ack;
  logic          ld_done;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          cpu_done;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          owner;

  // datapath side
  logic [DW-1:0] mdr_in;
  logic [AW-1:0] MARSpcIn;
  logic          ldMARSpcIn;
  logic          ldMAR;
  logic [DW-1:0] MDRSpcIn;
  logic          ldMDR;
  logic [1:0]    selMDR;
  logic          memWE;

  modport master (
    input  run_en, ld_req, ld_we, ld_addr, ld_wdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mdr_in,
    output ld_ack, ld_done, cpu_ack, cpu_done, rd_data, busy, owner,
    output MARSpcIn, ldMARSpcIn, ldMAR, MDRSpcIn, ldMDR, selMDR, memWE
  );

  modport slave (
    output run_en, ld_req, ld_we, ld_addr, ld_wdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mdr_in,
    input  ld_ack, ld_done, cpu_ack, cpu_done, rd_data, busy, owner,
    input  MARSpcIn, ldMARSpcIn, ldMAR, MDRSpcIn, ldMDR, selMDR, memWE
  );

endinterface

// File: rtl/lc3_mem_sequencer.sv
// Sequences loader and CPU transactions over the shared MAR/MDR/memory path.
// Loader has fixed priority; a granted transaction always runs to DONE.
module lc3_mem_sequencer
  import lc3_mem_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  lc3_mem_sequencer_if.master bus
);

  // Last value of the read wait counter; unused when MEM_LAT is 0 since RWAIT is skipped
  localparam logic [2:0] CNT_LAST = (MEM_LAT == 0) ? 3'd0 : 3'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          owner_q, owner_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic          ld_ack, cpu_ack;
  logic          ld_done, cpu_done;
  logic [AW-1:0] mar_spc;
  logic          ld_mar;
  logic [DW-1:0] mdr_spc;
  logic          ld_mdr;
  logic [1:0]    sel_mdr;
  logic          mem_we;

  // State and transaction registers; async reset aborts any in-flight write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      owner_q   <= OWN_CPU;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      owner_q   <= owner_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Arbitration, request capture and next-state sequencing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    owner_d   = owner_q;
    rd_data_d = rd_data_q;
    ld_ack    = 1'b0;
    cpu_ack   = 1'b0;
    case (state_q)
      IDLE: begin
        // requests are only looked at here, so nothing preempts a running transaction
        if (bus.ld_req) begin
          owner_d = OWN_LD;
          addr_d  = bus.ld_addr;
          wdata_d = bus.ld_wdata;
          we_d    = bus.ld_we;
          ld_ack  = 1'b1;
          state_d = ADDR;
        end else if (bus.cpu_req && bus.run_en) begin
          owner_d = OWN_CPU;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          we_d    = bus.cpu_we;
          cpu_ack = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        cnt_d = 3'd0;
        if (we_q) begin
          state_d = WDATA;
        end else if (MEM_LAT == 0) begin
          state_d = RLOAD;
        end else begin
          state_d = RWAIT;
        end
      end
      WDATA: state_d = WRITE;
      WRITE: state_d = DONE;
      RWAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 3'd0;
          state_d = RLOAD;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RLOAD: state_d = RCAPT;
      RCAPT: begin
        // MDR was loaded from memory in RLOAD, so mdr_in is settled now
        rd_data_d = bus.mdr_in;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore decode of datapath controls and done pulses from the state register
  always_comb begin
    mar_spc  = '0;
    ld_mar   = 1'b0;
    mdr_spc  = '0;
    ld_mdr   = 1'b0;
    sel_mdr  = SEL_MDR_NONE;
    mem_we   = 1'b0;
    ld_done  = 1'b0;
    cpu_done = 1'b0;
    case (state_q)
      ADDR: begin
        ld_mar  = 1'b1;
        mar_spc = addr_q;
      end
      WDATA: begin
        ld_mdr  = 1'b1;
        sel_mdr = SEL_MDR_SPC;
        mdr_spc = wdata_q;
      end
      WRITE: mem_we = 1'b1;
      RLOAD: begin
        ld_mdr  = 1'b1;
        sel_mdr = SEL_MDR_MEM;
      end
      DONE: begin
        ld_done  = (owner_q == OWN_LD);
        cpu_done = (owner_q == OWN_CPU);
      end
      default: ;
    endcase
  end

  assign bus.ld_ack     = ld_ack;
  assign bus.cpu_ack    = cpu_ack;
  assign bus.ld_done    = ld_done;
  assign bus.cpu_done   = cpu_done;
  assign bus.rd_data    = rd_data_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.owner      = owner_q;
  assign bus.MARSpcIn   = mar_spc;
  assign bus.ldMARSpcIn = ld_mar;
  assign bus.ldMAR      = ld_mar;
  assign bus.MDRSpcIn   = mdr_spc;
  assign bus.ldMDR      = ld_mdr;
  assign bus.selMDR     = sel_mdr;
  assign bus.memWE      = mem_we;

endmodule
